// File: rtl/simple_cpu_core_if.sv
// simple_cpu_core_if
//   Memory bus between the accumulator CPU and its 256x24 synchronous memory.
//   Signals:
//     MAR       CPU -> MEM  memory address
//     data_out  CPU -> MEM  write data
//     Mem_EN    CPU -> MEM  1=write, 0=read (qualified by Mem_CS)
//     Mem_CS    CPU -> MEM  one-cycle chip-select pulse per access
//     data_in   MEM -> CPU  read data, valid the cycle after the read pulse
//   Modports: master (CPU side), slave (memory side).
interface simple_cpu_core_if #(
  parameter int AW = 8,
  parameter int DW = 24
);
  logic [AW-1:0] MAR;
  logic [DW-1:0] data_out;
  logic [DW-1:0] data_in;
  logic          Mem_EN;
  logic          Mem_CS;

  modport master (
    output MAR,
    output data_out,
    output Mem_EN,
    output Mem_CS,
    input  data_in
  );

  modport slave (
    input  MAR,
    input  data_out,
    input  Mem_EN,
    input  Mem_CS,
    output data_in
  );
endinterface

// File: rtl/simple_cpu_core.sv
// simple_cpu_core
//   Accumulator CPU: fetches 24-bit instructions ([23:16] opcode, [15:8] unused,
//   [7:0] addr/imm) from a synchronous memory and executes them.
//   Ports:
//     clock  in   system clock, all state on posedge
//     reset  in   asynchronous, active-high reset
//     bus    simple_cpu_core_if.master (MAR, data_out, Mem_EN, Mem_CS, data_in)
//   Optional feature: define SIMPLE_CPU_MUL_EN to add opcode 09 MUL
//   (AC <= low 24 bits of AC*M[a], Z updated, C cleared). Without it 09 is a NOP.
//   Bus outputs are registered; each access is a single-cycle Mem_CS pulse that
//   is high during the cycle of the state that owns it.
module simple_cpu_core #(
  parameter int AW = 8,
  parameter int DW = 24
) (
  input  logic               clock,
  input  logic               reset,
  simple_cpu_core_if.master  bus
);

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_SUB   = 8'h04;
  localparam logic [7:0] OP_AND   = 8'h05;
  localparam logic [7:0] OP_LDI   = 8'h06;
  localparam logic [7:0] OP_JMP   = 8'h07;
  localparam logic [7:0] OP_JZ    = 8'h08;
`ifdef SIMPLE_CPU_MUL_EN
  localparam logic [7:0] OP_MUL   = 8'h09;
`endif
  localparam logic [7:0] OP_HALT  = 8'hFF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_FWAIT,
    S_DECODE,
    S_MRD,
    S_MWAIT,
    S_MWR,
    S_EXEC,
    S_HALT
  } state_t;

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [DW-1:0] ac_q;
  logic [7:0]    ir_op_q;
  logic [AW-1:0] ir_a_q;
  logic [DW-1:0] mbr_q;
  logic          z_q;
  logic          c_q;
  logic [AW-1:0] mar_q;
  logic [DW-1:0] dout_q;
  logic          cs_q;
  logic          en_q;

  logic [DW-1:0] ac_d;
  logic          z_d;
  logic          c_d;
  logic [AW-1:0] pc_d;
  logic          upd_z;
  logic          mem_op;
  logic [7:0]    in_op;

  assign in_op = bus.data_in[DW-1 -: 8];

  // Opcodes that need a memory operand read before EXEC.
  always_comb begin
    mem_op = 1'b0;
    case (ir_op_q)
      OP_LOAD, OP_ADD, OP_SUB, OP_AND: mem_op = 1'b1;
`ifdef SIMPLE_CPU_MUL_EN
      OP_MUL:                          mem_op = 1'b1;
`endif
      default:                         mem_op = 1'b0;
    endcase
  end

  // EXEC results: accumulator, flags and program counter.
  always_comb begin
    ac_d  = ac_q;
    c_d   = c_q;
    pc_d  = pc_q;
    upd_z = 1'b0;
    case (ir_op_q)
      OP_LOAD: begin
        ac_d  = mbr_q;
        upd_z = 1'b1;
      end
      OP_ADD: begin
        {c_d, ac_d} = {1'b0, ac_q} + {1'b0, mbr_q};
        upd_z       = 1'b1;
      end
      OP_SUB: begin
        // Bit DW of the widened difference is the borrow.
        {c_d, ac_d} = {1'b0, ac_q} - {1'b0, mbr_q};
        upd_z       = 1'b1;
      end
      OP_AND: begin
        ac_d  = ac_q & mbr_q;
        upd_z = 1'b1;
      end
      OP_LDI: begin
        ac_d  = {{(DW-AW){1'b0}}, ir_a_q};
        upd_z = 1'b1;
      end
      OP_JMP: pc_d = ir_a_q;
      OP_JZ: begin
        if (z_q) pc_d = ir_a_q;
      end
`ifdef SIMPLE_CPU_MUL_EN
      OP_MUL: begin
        ac_d  = ac_q * mbr_q;
        c_d   = 1'b0;
        upd_z = 1'b1;
      end
`endif
      default: ;
    endcase
    z_d = upd_z ? (ac_d == '0) : z_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ac_q    <= '0;
      ir_op_q <= '0;
      ir_a_q  <= '0;
      mbr_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      mar_q   <= '0;
      dout_q  <= '0;
      cs_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          // Normally entered with the fetch pulse already launched. Right after
          // reset the pulse is still low, so spend one cycle raising it.
          if (!cs_q) begin
            mar_q <= pc_q;
            cs_q  <= 1'b1;
            en_q  <= 1'b0;
          end else begin
            cs_q    <= 1'b0;
            en_q    <= 1'b0;
            state_q <= S_FWAIT;
          end
        end
        S_FWAIT: begin
          ir_op_q <= in_op;
          ir_a_q  <= bus.data_in[AW-1:0];
          pc_q    <= pc_q + AW'(1);
          state_q <= S_DECODE;
          // STORE's write pulse is launched from the incoming opcode so it lands
          // in DECODE; MWR then idles the bus, keeping the next fetch pulse from
          // being back-to-back while STORE still takes four cycles.
          if (in_op == OP_STORE) begin
            mar_q  <= bus.data_in[AW-1:0];
            dout_q <= ac_q;
            cs_q   <= 1'b1;
            en_q   <= 1'b1;
          end
        end
        S_DECODE: begin
          cs_q <= 1'b0;
          en_q <= 1'b0;
          if (ir_op_q == OP_STORE) begin
            state_q <= S_MWR;
          end else if (ir_op_q == OP_HALT) begin
            state_q <= S_HALT;
          end else if (mem_op) begin
            mar_q   <= ir_a_q;
            cs_q    <= 1'b1;
            state_q <= S_MRD;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_MRD: begin
          cs_q    <= 1'b0;
          en_q    <= 1'b0;
          state_q <= S_MWAIT;
        end
        S_MWAIT: begin
          mbr_q   <= bus.data_in;
          state_q <= S_EXEC;
        end
        S_MWR: begin
          mar_q   <= pc_q;
          cs_q    <= 1'b1;
          en_q    <= 1'b0;
          state_q <= S_FETCH;
        end
        S_EXEC: begin
          ac_q    <= ac_d;
          z_q     <= z_d;
          c_q     <= c_d;
          pc_q    <= pc_d;
          mar_q   <= pc_d;
          cs_q    <= 1'b1;
          en_q    <= 1'b0;
          state_q <= S_FETCH;
        end
        S_HALT: begin
          cs_q <= 1'b0;
          en_q <= 1'b0;
        end
        default: begin
          cs_q    <= 1'b0;
          en_q    <= 1'b0;
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  assign bus.MAR      = mar_q;
  assign bus.data_out = dout_q;
  assign bus.Mem_CS   = cs_q;
  assign bus.Mem_EN   = en_q;

endmodule

// File: tb/tb_simple_cpu_core.sv
// tb_simple_cpu_core
//   Directed bench for simple_cpu_core with a 256x24 synchronous memory model.
//   Every Mem_CS pulse is logged (cycle, address, write flag, data) so fetch
//   addresses and instruction latencies can be checked after each program runs.
module tb_simple_cpu_core;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  a;
    logic        en;
    logic [23:0] d;
  } pulse_t;

  logic        clk;
  logic        rst;
  logic        ld_we;
  logic        ld_clr;
  logic [7:0]  ld_a;
  logic [23:0] ld_d;
  logic [23:0] mem [0:255];
  pulse_t      pq [$];
  int unsigned cyc;
  int unsigned consec;
  logic        prev_cs;
  int          checks;
  int          failures;

  simple_cpu_core_if #(.AW(8), .DW(24)) bus ();

  simple_cpu_core #(.AW(8), .DW(24)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: read data registered one cycle after the read pulse; writes on the
  // write pulse; bench loader port used only while the CPU is held in reset.
  always @(posedge clk) begin
    if (ld_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (ld_we) begin
      mem[ld_a] <= ld_d;
    end else if (bus.Mem_CS && bus.Mem_EN) begin
      mem[bus.MAR] <= bus.data_out;
    end
    if (bus.Mem_CS && !bus.Mem_EN) bus.data_in <= mem[bus.MAR];
  end

  // Pulse log and back-to-back chip-select detector (values from the cycle
  // just ending).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && bus.Mem_CS)
      pq.push_back('{cyc: cyc, a: bus.MAR, en: bus.Mem_EN, d: bus.data_out});
    if (prev_cs && bus.Mem_CS) consec <= consec + 1;
    prev_cs <= bus.Mem_CS;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [23:0] d);
    ld_a  = a;
    ld_d  = d;
    ld_we = 1'b1;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic release_run(input int n, output int base);
    base = pq.size();
    rst  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int  b;
    bit  found;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    consec   = 0;
    prev_cs  = 1'b0;
    ld_we    = 1'b0;
    ld_a     = '0;
    ld_d     = '0;
    rst      = 1'b1;
    ld_clr   = 1'b1;
    @(negedge clk);
    ld_clr   = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_cs",   {31'b0, bus.Mem_CS}, 32'd0);
    chk("rst_en",   {31'b0, bus.Mem_EN}, 32'd0);
    chk("rst_mar",  {24'b0, bus.MAR}, 32'd0);
    chk("rst_dout", {8'b0, bus.data_out}, 32'd0);

    // LDI 5 / STORE 0x20 / HALT
    wr(8'h00, 24'h060005);
    wr(8'h01, 24'h020020);
    wr(8'h02, 24'hFF0000);
    wr(8'h20, 24'hABCDEF);

    // First pulse after release: fetch from 0
    rst   = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.Mem_CS) begin
        found = 1'b1;
        break;
      end
    end
    chk("first_pulse_seen", {31'b0, found}, 32'd1);
    chk("first_pulse_mar",  {24'b0, bus.MAR}, 32'd0);
    chk("first_pulse_en",   {31'b0, bus.Mem_EN}, 32'd0);

    // Reset asserted in the middle of the write pulse drops the bus at once
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.Mem_CS && bus.Mem_EN) begin
        found = 1'b1;
        break;
      end
    end
    chk("wr_pulse_seen", {31'b0, found}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_cs",   {31'b0, bus.Mem_CS}, 32'd0);
    chk("async_en",   {31'b0, bus.Mem_EN}, 32'd0);
    chk("async_mar",  {24'b0, bus.MAR}, 32'd0);
    chk("async_dout", {8'b0, bus.data_out}, 32'd0);
    @(negedge clk);
    chk("aborted_write", {8'b0, mem[8'h20]}, 32'hABCDEF);
    chk("async_ac",      {8'b0, dut.ac_q}, 32'd0);

    // Full run of the same program
    release_run(40, b);
    chk("p2_npulse",   pq.size() - b, 32'd4);
    chk("p2_f0_mar",   {24'b0, pq[b].a}, 32'h00);
    chk("p2_ldi_lat",  pq[b+1].cyc - pq[b].cyc, 32'd4);
    chk("p2_w_mar",    {24'b0, pq[b+2].a}, 32'h20);
    chk("p2_w_en",     {31'b0, pq[b+2].en}, 32'd1);
    chk("p2_w_data",   {8'b0, pq[b+2].d}, 32'h000005);
    chk("p2_st_lat",   pq[b+3].cyc - pq[b+1].cyc, 32'd4);
    chk("p2_mem20",    {8'b0, mem[8'h20]}, 32'h000005);
    chk("p2_halt_cs",  {31'b0, bus.Mem_CS}, 32'd0);

    // LOAD 10 / ADD 10 / STORE 11 / HALT
    hold_reset();
    wr(8'h00, 24'h01000A);
    wr(8'h01, 24'h03000A);
    wr(8'h02, 24'h02000B);
    wr(8'h03, 24'hFF0000);
    wr(8'h0A, 24'h000007);
    release_run(40, b);
    chk("p3_npulse",   pq.size() - b, 32'd7);
    chk("p3_rd_mar",   {24'b0, pq[b+1].a}, 32'h0A);
    chk("p3_rd_en",    {31'b0, pq[b+1].en}, 32'd0);
    chk("p3_load_lat", pq[b+2].cyc - pq[b].cyc, 32'd6);
    chk("p3_mem11",    {8'b0, mem[8'h0B]}, 32'h00000E);
    chk("p3_z",        {31'b0, dut.z_q}, 32'd0);
    chk("p3_c",        {31'b0, dut.c_q}, 32'd0);

    // LOAD FFFFFF / ADD 1 -> 0 with carry; JZ 0x40 taken
    hold_reset();
    wr(8'h00, 24'h010030);
    wr(8'h01, 24'h030031);
    wr(8'h02, 24'h080040);
    wr(8'h03, 24'hFF0000);
    wr(8'h30, 24'hFFFFFF);
    wr(8'h31, 24'h000001);
    wr(8'h40, 24'h020050);
    wr(8'h41, 24'hFF0000);
    wr(8'h50, 24'h123456);
    release_run(50, b);
    chk("p4_c",       {31'b0, dut.c_q}, 32'd1);
    chk("p4_z",       {31'b0, dut.z_q}, 32'd1);
    chk("p4_jz_mar",  {24'b0, pq[b+5].a}, 32'h40);
    chk("p4_mem50",   {8'b0, mem[8'h50]}, 32'h000000);

    // LDI 1 / JZ 0x40 not taken / STORE 51
    hold_reset();
    wr(8'h00, 24'h060001);
    wr(8'h01, 24'h080040);
    wr(8'h02, 24'h020051);
    wr(8'h03, 24'hFF0000);
    release_run(40, b);
    chk("p4b_fall_mar", {24'b0, pq[b+2].a}, 32'h02);
    chk("p4b_mem51",    {8'b0, mem[8'h51]}, 32'h000001);

    // LDI 2 / SUB 3 -> FFFFFF with borrow
    hold_reset();
    wr(8'h00, 24'h060002);
    wr(8'h01, 24'h040032);
    wr(8'h02, 24'h020052);
    wr(8'h03, 24'hFF0000);
    wr(8'h32, 24'h000003);
    release_run(40, b);
    chk("sub_mem52", {8'b0, mem[8'h52]}, 32'hFFFFFF);
    chk("sub_c",     {31'b0, dut.c_q}, 32'd1);
    chk("sub_z",     {31'b0, dut.z_q}, 32'd0);

    // JMP 0xFF with NOP at 0xFF: PC wraps to 0 and loops
    hold_reset();
    wr(8'h00, 24'h0700FF);
    wr(8'hFF, 24'h000000);
    release_run(30, b);
    chk("wrap_jmp_mar", {24'b0, pq[b+1].a}, 32'hFF);
    chk("wrap_mar",     {24'b0, pq[b+2].a}, 32'h00);
    chk("wrap_loop",    {24'b0, pq[b+3].a}, 32'hFF);

    // JMP to itself loops forever on address 0
    hold_reset();
    wr(8'h00, 24'h070000);
    release_run(30, b);
    chk("self_npulse_ge6", {31'b0, (pq.size() - b) >= 6}, 32'd1);
    chk("self_mar",        {24'b0, pq[b+5].a}, 32'h00);
    chk("self_lat",        pq[b+5].cyc - pq[b+4].cyc, 32'd4);

    // Unknown opcode 3C behaves as NOP
    hold_reset();
    wr(8'h00, 24'h060007);
    wr(8'h01, 24'h3C0055);
    wr(8'h02, 24'h020053);
    wr(8'h03, 24'hFF0000);
    release_run(40, b);
    chk("op3c_next_mar", {24'b0, pq[b+2].a}, 32'h02);
    chk("op3c_lat",      pq[b+2].cyc - pq[b+1].cyc, 32'd4);
    chk("op3c_mem53",    {8'b0, mem[8'h53]}, 32'h000007);

    // Opcode 09: MUL when enabled, NOP otherwise
    hold_reset();
    wr(8'h00, 24'h060003);
    wr(8'h01, 24'h090034);
    wr(8'h02, 24'h020054);
    wr(8'h03, 24'hFF0000);
    wr(8'h34, 24'h000005);
    release_run(40, b);
`ifdef SIMPLE_CPU_MUL_EN
    chk("mul_mem54",   {8'b0, mem[8'h54]}, 32'h00000F);
    chk("mul_rd_mar",  {24'b0, pq[b+2].a}, 32'h34);
    chk("mul_c",       {31'b0, dut.c_q}, 32'd0);
`else
    chk("op09_mem54",  {8'b0, mem[8'h54]}, 32'h000003);
    chk("op09_next",   {24'b0, pq[b+2].a}, 32'h02);
`endif

    chk("no_b2b_cs", consec, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
